nibble_pipe_adder: RTL and testbench
====================================

NIBBLE_PIPE_ADDER -- requirements
Module: nibble_pipe_adder

Interface
REQ-001 The block SHALL have parameter NIBBLES, default 4, giving the number of 4-bit slices; the operand width W = 4*NIBBLES.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port in_valid, input, 1 bit: the operands are presented this cycle.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block accepts the operands this cycle.
REQ-006 The block SHALL have ports a and b, input, W bits each: the unsigned/two's-complement operands.
REQ-007 The block SHALL have port cin, input, 1 bit: carry into slice 0.
REQ-008 The block SHALL have port out_valid, output, 1 bit: the result ports hold a valid result.
REQ-009 The block SHALL have port out_ready, input, 1 bit: the consumer takes the result this cycle.
REQ-010 The block SHALL have port sum, output, W bits: a+b+cin modulo 2^W.
REQ-011 The block SHALL have port cout, output, 1 bit: carry out of the MSB.
REQ-012 The block SHALL have port ovf, output, 1 bit: signed overflow, meaning a[W-1]==b[W-1] and sum[W-1]!=a[W-1].

Function
REQ-013 The block SHALL be a NIBBLES-stage pipeline; stage k adds nibble k with 4-bit carry-lookahead logic: G/P per bit and carries c1..c4 as flat sum-of-products of G, P and the stage carry-in, with no ripple.
REQ-014 Stage k SHALL register the stage carry-out, the sum nibbles 0..k and the still-unprocessed operand nibbles k+1..NIBBLES-1. The operand nibbles are carried forward through skew registers.
REQ-015 Each stage SHALL carry a valid bit; empty stages are bubbles and their data is don't-care.
REQ-016 Define advance = !out_valid || out_ready; when advance=1 every stage SHALL shift one position; when advance=0 every stage SHALL hold all its contents.
REQ-017 in_ready SHALL equal advance (combinational); a transfer occurs when in_valid && in_ready.
REQ-018 When advance=1 and in_valid=0, a bubble (valid=0) SHALL enter stage 0.
REQ-019 Latency SHALL be exactly NIBBLES cycles: operands accepted at edge n appear with out_valid=1 after edge n+NIBBLES-1, given no stall.
REQ-020 Throughput SHALL be one result per cycle with no bubbles while out_ready=1 and in_valid=1.
REQ-021 sum, cout and ovf SHALL be driven directly from the final-stage registers, with no output combinational path from a, b or cin.
REQ-022 While out_valid=1 and out_ready=0, sum, cout and ovf SHALL remain stable.
REQ-023 Results SHALL leave in acceptance order; none SHALL be dropped or duplicated.
REQ-024 An in_valid=1 with in_ready=0 SHALL not be captured; the upstream holds the operands.
REQ-025 Carries SHALL wrap modulo 2^W; ovf SHALL be computed from the sign bits of the original operands, which are carried in the skew registers.

Reset
REQ-026 When rst_n=0 at a rising edge, all stage valid bits SHALL clear. After that edge out_valid=0, sum=0, cout=0 and ovf=0.
REQ-027 Operations in flight when reset is applied SHALL be discarded; none emerges afterwards.
REQ-028 During reset in_ready SHALL read 1, because out_valid=0. Any transfer attempted in a reset cycle SHALL be discarded.
REQ-029 The first operand accepted after rst_n returns to 1 SHALL produce its result with the normal latency.

Verification (NIBBLES=4)
REQ-030 Single add: a=0x1234, b=0x4321, cin=0 with out_ready=1 -> exactly 4 cycles later out_valid=1, sum=0x5555, cout=0, ovf=0.
REQ-031 Carry chain: a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0. Then a=0xFFFF, b=0xFFFF, cin=1 -> sum=0xFFFF, cout=1, ovf=0.
REQ-032 Overflow: a=0x7FFF, b=0x0001 -> sum=0x8000, ovf=1, cout=0. Then a=0x8000, b=0x8000 -> sum=0x0000, ovf=1, cout=1.
REQ-033 Streaming with backpressure: issue 8 back-to-back random adds and drop out_ready for 3 cycles mid-stream -> in_ready=0 exactly while out_valid=1 and out_ready=0, outputs held stable, all 8 results correct and in order.
REQ-034 Reset mid-flight: accept 3 adds, assert rst_n=0 for 1 cycle -> out_valid=0 next cycle and stays 0; a fresh add afterwards is returned alone after 4 cycles.
REQ-035 Bubbles: in_valid pattern 1,0,1,0 with out_ready=1 -> out_valid pattern 1,0,1,0 starting 4 cycles after the first accept, with correct sums.

Source files
------------

// File: rtl/nibble_pipe_adder.sv
// Pipelined adder: one 4-bit carry-lookahead slice per stage, NIBBLES stages deep,
// with a single global stall (advance) driven by output backpressure.
module nibble_pipe_adder #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    input  logic                   cin,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NIBBLES-1:0]   sum,
    output logic                   cout,
    output logic                   ovf
);

    // Returns {c4, s[3:0]}; every carry is a flat sum-of-products of g, p and ci.
    function automatic logic [4:0] cla4(input logic [3:0] x,
                                        input logic [3:0] y,
                                        input logic       ci);
        logic [3:0] g;
        logic [3:0] p;
        logic       c1, c2, c3, c4;
        g  = x & y;
        p  = x ^ y;
        c1 = g[0] | (p[0] & ci);
        c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                  | (p[3] & p[2] & p[1] & p[0] & ci);
        return {c4, p ^ {c3, c2, c1, ci}};
    endfunction

    logic advance;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    for (genvar k = 0; k < NIBBLES; k++) begin : stg
        localparam int unsigned SW = 4 * (k + 1);
        localparam int unsigned OW = 4 * (NIBBLES - 1 - k);

        logic [3:0]    xa;
        logic [3:0]    xb;
        logic          ci;
        logic          vi;
        logic [4:0]    r;
        logic [SW-1:0] sum_d;
        logic          v_q;
        logic          c_q;
        logic [SW-1:0] sum_q;

        assign r = cla4(xa, xb, ci);

        if (k == 0) begin : src
            assign xa    = a[3:0];
            assign xb    = b[3:0];
            assign ci    = cin;
            assign vi    = in_valid;
            assign sum_d = r[3:0];
        end else begin : src
            assign xa    = stg[k-1].fwd.a_q[3:0];
            assign xb    = stg[k-1].fwd.b_q[3:0];
            assign ci    = stg[k-1].c_q;
            assign vi    = stg[k-1].v_q;
            assign sum_d = {r[3:0], stg[k-1].sum_q};
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                v_q   <= 1'b0;
                c_q   <= 1'b0;
                sum_q <= '0;
            end else if (advance) begin
                v_q   <= vi;
                c_q   <= r[4];
                sum_q <= sum_d;
            end
        end

        // Skew registers keep the unprocessed nibbles right-aligned: the next slice's nibble sits at [3:0].
        if (k < NIBBLES - 1) begin : fwd
            logic [OW-1:0] a_d;
            logic [OW-1:0] b_d;
            logic [OW-1:0] a_q;
            logic [OW-1:0] b_q;

            if (k == 0) begin : ld
                assign a_d = a[4*NIBBLES-1:4];
                assign b_d = b[4*NIBBLES-1:4];
            end else begin : ld
                assign a_d = stg[k-1].fwd.a_q[OW+3:4];
                assign b_d = stg[k-1].fwd.b_q[OW+3:4];
            end

            always_ff @(posedge clk) begin
                if (advance) begin
                    a_q <= a_d;
                    b_q <= b_d;
                end
            end
        end

        // The last slice's operand nibble holds the original sign bits, so overflow is resolved here.
        if (k == NIBBLES - 1) begin : fin
            logic ovf_q;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    ovf_q <= 1'b0;
                end else if (advance) begin
                    ovf_q <= (xa[3] == xb[3]) && (r[3] != xa[3]);
                end
            end
        end
    end

    assign out_valid = stg[NIBBLES-1].v_q;
    assign sum       = stg[NIBBLES-1].sum_q;
    assign cout      = stg[NIBBLES-1].c_q;
    assign ovf       = stg[NIBBLES-1].fin.ovf_q;

endmodule

// File: tb/tb_nibble_pipe_adder.sv
// Scoreboard bench for nibble_pipe_adder (NIBBLES=4): expected results are queued on
// acceptance and checked, with exact latency, when the DUT hands them over.
module tb_nibble_pipe_adder;

    localparam int unsigned NIB = 4;
    localparam int unsigned W   = 4 * NIB;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    nibble_pipe_adder #(.NIBBLES(NIB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W+1:0] res;
        int           acc;
        int           st;
    } sb_entry_t;

    sb_entry_t    sb[$];
    int           n_vec     = 0;
    int           n_miss    = 0;
    int           cyc       = 0;
    int           stall_ctr = 0;
    logic         hold_v    = 1'b0;
    logic [W+1:0] hold_d;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c);
        logic [W:0] full;
        logic       o;
        full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
        o    = (x[W-1] == y[W-1]) && (full[W-1] != x[W-1]);
        return {o, full[W], full[W-1:0]};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        sb_entry_t e;
        if (!rst_n) begin
            sb.delete();
            hold_v = 1'b0;
        end else begin
            check("in_ready", {31'd0, in_ready}, {31'd0, (!out_valid || out_ready)});
            if (hold_v) begin
                check("hold_valid", {31'd0, out_valid}, 32'd1);
                check("hold_data", {14'd0, ovf, cout, sum}, {14'd0, hold_d});
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("spurious", {31'd0, out_valid}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("result", {14'd0, ovf, cout, sum}, {14'd0, e.res});
                    check("latency", cyc, e.acc + NIB - 1 + stall_ctr - e.st);
                end
            end
            hold_v = out_valid && !out_ready;
            hold_d = {ovf, cout, sum};
            if (hold_v) stall_ctr++;
            if (in_valid && in_ready) begin
                e.res = model(a, b, cin);
                e.acc = cyc + 1;
                e.st  = stall_ctr;
                sb.push_back(e);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        logic took;
        took     = 1'b0;
        in_valid = 1'b1;
        a        = x;
        b        = y;
        cin      = c;
        for (int unsigned i = 0; i < 50; i++) begin
            @(negedge clk);
            took = in_ready;
            tick();
            if (took) break;
        end
        if (!took) check("accept_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int unsigned i = 0; i < 40; i++) begin
            if (sb.size() == 0) break;
            tick();
        end
        check("drain", sb.size(), 32'd0);
    endtask

    task automatic check_reset_outputs();
        @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_sum", {16'd0, sum}, 32'd0);
        check("rst_cout", {31'd0, cout}, 32'd0);
        check("rst_ovf", {31'd0, ovf}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        repeat (3) tick();
        check_reset_outputs();
        tick();
        rst_n = 1'b1;

        send(16'h1234, 16'h4321, 1'b0);
        drain();

        send(16'hFFFF, 16'h0001, 1'b0);
        send(16'hFFFF, 16'hFFFF, 1'b1);
        drain();

        send(16'h7FFF, 16'h0001, 1'b0);
        send(16'h8000, 16'h8000, 1'b0);
        drain();

        fork
            begin
                for (int unsigned i = 0; i < 8; i++)
                    send(W'($urandom), W'($urandom), 1'($urandom));
            end
            begin
                repeat (5) tick();
                out_ready = 1'b0;
                repeat (3) tick();
                out_ready = 1'b1;
            end
        join
        drain();

        send(16'h1111, 16'h2222, 1'b0);
        send(16'h3333, 16'h4444, 1'b1);
        send(16'h5555, 16'h6666, 1'b0);
        rst_n    = 1'b0;
        in_valid = 1'b1;
        a        = 16'hABCD;
        b        = 16'h1357;
        tick();
        rst_n    = 1'b1;
        in_valid = 1'b0;
        check_reset_outputs();
        repeat (6) tick();
        send(16'h0F0F, 16'hF0F1, 1'b0);
        drain();

        send(16'h2468, 16'h1357, 1'b0);
        tick();
        send(16'h9999, 16'h9999, 1'b1);
        tick();
        drain();

        repeat (4) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
